multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Moore FSM that sequences the multicycle MIPS datapath: fetch, decode, execute, memory and writeback.
//  Sits inside CPU next to Registers and InstructionMemory; it drives every mux select and write strobe.
//  A mem_ready handshake stretches the memory states, so the block tolerates a multi-cycle shared memory.
//  Halts on an unsupported opcode and counts retired instructions.
// PARAMETERS
//  RETIRE_W  32  width of the retired-instruction counter (wraps modulo 2^RETIRE_W)
// PORTS
//  clock          in   1   single clock; all state changes on posedge
//  reset          in   1   synchronous, active-high
//  opcode         in   6   IR[31:26], valid from DECODE onward
//  mem_ready      in   1   memory completes the current read/write this cycle
//  pc_write       out  1   unconditional PC load
//  pc_write_cond  out  1   PC load if ALU zero (beq)
//  i_or_d         out  1   0 = memory address from PC, 1 = from ALUOut
//  mem_read       out  1   memory read request
//  mem_write      out  1   memory write request
//  ir_write       out  1   load the instruction register
//  mem_to_reg     out  1   1 = write MDR to register file, 0 = ALUOut
//  reg_dst        out  1   1 = rd, 0 = rt
//  reg_write      out  1   register file write enable
//  alu_src_a      out  1   0 = PC, 1 = register A
//  alu_src_b      out  2   00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
//  alu_op         out  2   00 = add, 01 = sub, 10 = use funct
//  pc_source      out  2   00 = ALU result, 01 = ALUOut, 10 = jump target
//  illegal        out  1   sticky; set on entry to TRAP
//  state          out  4   current state encoding (debug)
//  retire_count   out  RETIRE_W  instructions completed since reset
// BEHAVIOUR
//  - Reset: the state register loads FETCH, retire_count and illegal clear to 0.
//    While reset is high, pc_write, pc_write_cond, ir_write, mem_read, mem_write and reg_write are forced to 0.
//    All other outputs take the FETCH values.
//  - Every output is 0 unless it is listed for the current state.
//  - Opcode dispatch: R-type 6'h00, lw 6'h23, sw 6'h2B, beq 6'h04, addi 6'h08, j 6'h02.
//  - States and transitions:
//    FETCH(0): mem_read=1, i_or_d=0, alu_src_b=01, alu_op=00, pc_source=00.
//      Hold in FETCH while mem_ready=0.
//      When mem_ready=1: ir_write=1 and pc_write=1 in that same cycle (Mealy), then go to DECODE.
//    DECODE(1): alu_src_b=11, alu_op=00. Next state by opcode:
//      lw/sw -> MEM_ADDR, R-type -> R_EXEC, beq -> BRANCH, addi -> ADDI_EXEC, j -> JUMP, any other -> TRAP.
//    MEM_ADDR(2): alu_src_a=1, alu_src_b=10. Next state: lw -> MEM_READ, sw -> MEM_WRITE.
//    MEM_READ(3): mem_read=1, i_or_d=1. Hold until mem_ready=1, then go to MEM_WB.
//    MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH and retire.
//    MEM_WRITE(5): mem_write=1, i_or_d=1. Hold until mem_ready=1, then go to FETCH and retire.
//    R_EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10. Go to R_WB.
//    R_WB(7): reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH and retire.
//    BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Go to FETCH and retire.
//    ADDI_EXEC(9): alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDI_WB.
//    ADDI_WB(10): reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH and retire.
//    JUMP(11): pc_write=1, pc_source=10. Go to FETCH and retire.
//    TRAP(12): all strobes 0, illegal=1. Absorbing; only reset leaves it.
//  - Encodings 13-15 are unreachable; if ever entered, the next state is FETCH.
//  - Retire: retire_count increments by 1 on the edge that enters FETCH from any retiring state.
//  - Latency with mem_ready tied to 1:
//    R-type, addi and lw are 4, 4 and 5 cycles; sw, beq and j are 4, 3 and 3 cycles.
//    Each cycle that mem_ready is held low adds 1 cycle.
//  - Reset has priority over mem_ready and the opcode in the same cycle.
//    Reset mid-instruction (for example during a MEM_WRITE wait) abandons it; no partial retire is counted.
// STRUCTURE
//  - State encodings and opcode constants go in the shared constants.h (`include), beside the existing defines.
//  - Natural sub-module: control_next_state, the combinational next-state function of (state, opcode, mem_ready).
//  - Output decode and the retire counter stay in this module.
// TESTING
//  1. R-type add (opcode 0), mem_ready=1 -> states 0,1,6,7,0; reg_write=1 and reg_dst=1 in state 7 only; retire_count 0->1.
//  2. lw (6'h23) with mem_ready low 2 cycles in MEM_READ -> 7 cycles total; mem_to_reg=1 in MEM_WB; i_or_d=1 in state 3.
//  3. beq (6'h04) -> 3 cycles; in state 8 pc_write_cond=1, alu_op=01, pc_source=01; pc_write=0 throughout.
//  4. FETCH with mem_ready=0 for 3 cycles -> mem_read held at 1; ir_write and pc_write stay 0 until the ready cycle, then pulse once.
//  5. opcode 6'h3F -> TRAP (state=12) and illegal=1 for 10+ cycles with all strobes 0; reset -> FETCH, illegal=0.
//  6. sw (6'h2B) with reset asserted while waiting in MEM_WRITE -> mem_write=0 during reset; state=0 after the edge; retire_count=0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Holds the state encoding, the supported opcodes and the mux-select
// codes. The control FSM and its next-state function both import this package.
package multicycle_control_pkg;

  // State encodings. They are visible on the debug state port, so the
  // values are fixed. Encodings 13-15 are never used.
  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_ADDI_EXEC = 4'd9,
    ST_ADDI_WB   = 4'd10,
    ST_JUMP      = 4'd11,
    ST_TRAP      = 4'd12
  } state_t;

  // Supported opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  // ALU B-input select
  localparam logic [1:0] ALUB_REG      = 2'b00;
  localparam logic [1:0] ALUB_FOUR     = 2'b01;
  localparam logic [1:0] ALUB_IMM      = 2'b10;
  localparam logic [1:0] ALUB_IMM_SHL2 = 2'b11;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_next_state.sv
// Combinational next-state function of the multicycle control FSM.
// Ports:
//   state      in  4  current state register (raw, so 13-15 can be seen)
//   opcode     in  6  IR[31:26]
//   mem_ready  in  1  shared memory completes the current access
//   next_state out 4  state to load on the next clock edge
//   retire     out 1  an instruction completes on the next clock edge
module multicycle_control_next_state
  import multicycle_control_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [3:0] next_state,
  output logic       retire
);

  always_comb begin
    next_state = ST_FETCH;
    retire     = 1'b0;
    case (state)
      ST_FETCH:     next_state = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = ST_MEM_ADDR;
          OP_RTYPE:     next_state = ST_R_EXEC;
          OP_BEQ:       next_state = ST_BRANCH;
          OP_ADDI:      next_state = ST_ADDI_EXEC;
          OP_J:         next_state = ST_JUMP;
          default:      next_state = ST_TRAP;
        endcase
      end
      // Only lw and sw reach MEM_ADDR, so anything other than lw is a store.
      ST_MEM_ADDR:  next_state = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  next_state = mem_ready ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WRITE: begin
        next_state = mem_ready ? ST_FETCH : ST_MEM_WRITE;
        retire     = mem_ready;
      end
      ST_R_EXEC:    next_state = ST_R_WB;
      ST_ADDI_EXEC: next_state = ST_ADDI_WB;
      ST_MEM_WB, ST_R_WB, ST_ADDI_WB, ST_BRANCH, ST_JUMP: begin
        next_state = ST_FETCH;
        retire     = 1'b1;
      end
      ST_TRAP:      next_state = ST_TRAP;
      // Unused encodings recover to FETCH without counting a retire.
      default:      next_state = ST_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath.
// It steps through fetch, decode, execute, memory and writeback. It stretches
// the memory states with the mem_ready handshake. It halts in TRAP on an
// unsupported opcode and counts retired instructions.
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   opcode, mem_ready       IR[31:26] and the memory completion handshake
//   pc_write .. pc_source   datapath mux selects and write strobes
//   illegal                 sticky flag, set on entry to TRAP
//   state                   current state encoding (debug)
//   retire_count            instructions completed since reset
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic                illegal,
  output logic [3:0]          state,
  output logic [RETIRE_W-1:0] retire_count
);

  logic [3:0]          state_q;
  logic [3:0]          next_state;
  logic                retire;
  logic                illegal_q;
  logic [RETIRE_W-1:0] retire_q;
  logic [3:0]          dec_state;

  multicycle_control_next_state u_next_state (
    .state      (state_q),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .next_state (next_state),
    .retire     (retire)
  );

  // State register, sticky illegal flag and retire counter.
  // A reset mid-instruction drops that instruction without counting it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
      retire_q  <= '0;
    end else begin
      state_q <= next_state;
      if (next_state == ST_TRAP)
        illegal_q <= 1'b1;
      if (retire)
        retire_q <= retire_q + RETIRE_W'(1);
    end
  end

  // While reset is high, the outputs show the FETCH values with every strobe off.
  // This holds even if the state register still holds an abandoned state.
  assign dec_state = reset ? ST_FETCH : state_q;

  // Output decode. Everything defaults to 0. FETCH is the only Mealy state:
  // the IR load and the PC+4 write happen in the cycle the memory delivers.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_REG;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    case (dec_state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE:    alu_src_b = ALUB_IMM_SHL2;
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
      end
      ST_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      ST_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      ST_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
      end
      ST_ADDI_WB:   reg_write = 1'b1;
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
    end
  end

  assign illegal      = illegal_q;
  assign state        = state_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control.
// Inputs are driven on the falling edge. Outputs are sampled 1 ns later.
// The reference model turns each instruction into its expected state walk.
// Each state maps to the control word listed for it.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [31:0] retire_count;
  ctrl_t       act;

  int checks = 0;
  int passes = 0;
  int exp_retire = 0;

  // Model trace: expected state per cycle and the mem_ready value to drive
  int         exp_q[$];
  bit         mr_q[$];
  logic [3:0] obs_state[$];
  ctrl_t      obs_ctrl[$];

  logic [5:0] legal_ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};

  multicycle_control dut (
    .clock         (clock),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal       (illegal),
    .state         (state),
    .retire_count  (retire_count)
  );

  assign act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, illegal};

  always #5 clock = ~clock;

  // Control word listed for each state. While reset is high, the outputs are
  // the FETCH values with every strobe cleared.
  function automatic ctrl_t exp_ctrl(int s, bit mr, bit rst);
    ctrl_t c = '0;
    if (rst) s = 0;
    case (s)
      0:  begin c.mem_read = !rst; c.alu_src_b = 2'b01;
                c.ir_write = mr && !rst; c.pc_write = mr && !rst; end
      1:  c.alu_src_b = 2'b11;
      2:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      3:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      4:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      5:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      6:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      7:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      8:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
                c.pc_source = 2'b01; end
      9:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      10: c.reg_write = 1'b1;
      11: begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      12: c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  // Append a state that lasts one cycle and ignores mem_ready.
  function automatic void push_plain(int s);
    exp_q.push_back(s);
    mr_q.push_back(1'($urandom_range(0, 1)));
  endfunction

  // Append a state that waits for memory: `stalls` not-ready cycles, then ready.
  function automatic void push_wait(int s, int stalls);
    for (int k = 0; k < stalls; k++) begin
      exp_q.push_back(s);
      mr_q.push_back(1'b0);
    end
    exp_q.push_back(s);
    mr_q.push_back(1'b1);
  endfunction

  // Reference model: the state walk of one instruction, starting in FETCH.
  // fs counts fetch stalls and ms counts data-memory stalls.
  function automatic void build_plan(logic [5:0] op, int fs, int ms);
    exp_q.delete();
    mr_q.delete();
    push_wait(0, fs);
    push_plain(1);
    case (op)
      6'h00: begin push_plain(6); push_plain(7); end
      6'h08: begin push_plain(9); push_plain(10); end
      6'h04: push_plain(8);
      6'h02: push_plain(11);
      6'h23: begin push_plain(2); push_wait(3, ms); push_plain(4); end
      6'h2B: begin push_plain(2); push_wait(5, ms); end
      default: push_plain(12);
    endcase
  endfunction

  // Replay the planned mem_ready values one cycle at a time and record
  // what the DUT shows in each cycle.
  task automatic drive_plan();
    obs_state.delete();
    obs_ctrl.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock);
      mem_ready = mr_q[i];
      #1;
      obs_state.push_back(state);
      obs_ctrl.push_back(act);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = 6'h00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    checks++;
    if (state !== 4'd0) $display("[TB] FAIL reset_state got %0d want 0", state);
    else passes++;
    checks++;
    if (act !== exp_ctrl(0, 1'b1, 1'b1))
      $display("[TB] FAIL reset_ctrl got %h want %h", act, exp_ctrl(0, 1'b1, 1'b1));
    else passes++;
    checks++;
    if (retire_count !== 32'd0) $display("[TB] FAIL reset_retire got %0d want 0", retire_count);
    else passes++;
    reset = 1'b0;
    mem_ready = 1'b0;
    exp_retire = 0;
    #1;
    checks++;
    if (act !== exp_ctrl(0, 1'b0, 1'b0))
      $display("[TB] FAIL fetch_idle_ctrl got %h want %h", act, exp_ctrl(0, 1'b0, 1'b0));
    else passes++;
  endtask

  // Run one instruction and check its full trace and the retire count.
  task automatic test_instruction(string name, logic [5:0] op, int fs, int ms);
    opcode = op;
    build_plan(op, fs, ms);
    drive_plan();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_state[i] !== 4'(exp_q[i]))
        $display("[TB] FAIL %s_state[%0d] got %0d want %0d", name, i, obs_state[i], exp_q[i]);
      else passes++;
      checks++;
      if (obs_ctrl[i] !== exp_ctrl(exp_q[i], mr_q[i], 1'b0))
        $display("[TB] FAIL %s_ctrl[%0d] got %h want %h", name, i, obs_ctrl[i],
                 exp_ctrl(exp_q[i], mr_q[i], 1'b0));
      else passes++;
    end
    exp_retire++;
    @(negedge clock);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0) $display("[TB] FAIL %s_back_to_fetch got %0d want 0", name, state);
    else passes++;
    checks++;
    if (retire_count !== 32'(exp_retire))
      $display("[TB] FAIL %s_retire got %0d want %0d", name, retire_count, exp_retire);
    else passes++;
  endtask

  // Count the cycles the DUT needs, reacting to its state.
  // The expected cycle counts are base latency plus injected stalls.
  task automatic test_latency();
    logic [5:0] ops [7] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h23};
    int         lat [7] = '{4, 4, 5, 4, 3, 3, 7};
    int         stl [7] = '{0, 0, 0, 0, 0, 0, 2};
    for (int t = 0; t < 7; t++) begin
      int cycles = 0;
      int left = stl[t];
      opcode = ops[t];
      while (cycles < 30) begin
        @(negedge clock);
        if (cycles > 0 && state == 4'd0) break;
        if ((state == 4'd3 || state == 4'd5) && left > 0) begin
          mem_ready = 1'b0;
          left--;
        end else begin
          mem_ready = 1'b1;
        end
        cycles++;
      end
      mem_ready = 1'b0;
      exp_retire++;
      checks++;
      if (cycles !== lat[t])
        $display("[TB] FAIL latency_op%h got %0d want %0d", ops[t], cycles, lat[t]);
      else passes++;
    end
    #1;
    checks++;
    if (retire_count !== 32'(exp_retire))
      $display("[TB] FAIL latency_retire got %0d want %0d", retire_count, exp_retire);
    else passes++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      logic [5:0] op = legal_ops[$urandom_range(0, 5)];
      test_instruction($sformatf("rand%0d", n), op, $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  // Reset while a store waits in MEM_WRITE. The store is dropped uncounted.
  task automatic test_reset_mid_sw();
    opcode = 6'h2B;
    build_plan(6'h2B, 0, 3);
    void'(exp_q.pop_back());
    void'(mr_q.pop_back());
    void'(exp_q.pop_back());
    void'(mr_q.pop_back());
    drive_plan();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_state[i] !== 4'(exp_q[i]))
        $display("[TB] FAIL sw_wait_state[%0d] got %0d want %0d", i, obs_state[i], exp_q[i]);
      else passes++;
    end
    @(negedge clock);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (act !== exp_ctrl(0, 1'b1, 1'b1))
      $display("[TB] FAIL sw_reset_ctrl got %h want %h", act, exp_ctrl(0, 1'b1, 1'b1));
    else passes++;
    @(negedge clock);
    #1;
    exp_retire = 0;
    checks++;
    if (state !== 4'd0) $display("[TB] FAIL sw_reset_state got %0d want 0", state);
    else passes++;
    checks++;
    if (retire_count !== 32'd0) $display("[TB] FAIL sw_reset_retire got %0d want 0", retire_count);
    else passes++;
    reset = 1'b0;
    mem_ready = 1'b0;
  endtask

  // An unsupported opcode parks the FSM in TRAP. Only reset releases it.
  task automatic test_trap();
    opcode = 6'h3F;
    build_plan(6'h3F, 0, 0);
    for (int k = 0; k < 11; k++) push_plain(12);
    drive_plan();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_state[i] !== 4'(exp_q[i]))
        $display("[TB] FAIL trap_state[%0d] got %0d want %0d", i, obs_state[i], exp_q[i]);
      else passes++;
      checks++;
      if (obs_ctrl[i] !== exp_ctrl(exp_q[i], mr_q[i], 1'b0))
        $display("[TB] FAIL trap_ctrl[%0d] got %h want %h", i, obs_ctrl[i],
                 exp_ctrl(exp_q[i], mr_q[i], 1'b0));
      else passes++;
    end
    checks++;
    if (retire_count !== 32'(exp_retire))
      $display("[TB] FAIL trap_retire got %0d want %0d", retire_count, exp_retire);
    else passes++;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0)
      $display("[TB] FAIL trap_reset got state=%0d illegal=%b want state=0 illegal=0", state, illegal);
    else passes++;
    reset = 1'b0;
    mem_ready = 1'b0;
    exp_retire = 0;
  endtask

  initial begin
    test_reset();
    test_instruction("rtype", 6'h00, 0, 0);
    test_instruction("lw_stall", 6'h23, 0, 2);
    test_instruction("beq", 6'h04, 0, 0);
    test_instruction("fetch_stall", 6'h08, 3, 0);
    test_instruction("jump", 6'h02, 1, 0);
    test_latency();
    test_random();
    test_reset_mid_sw();
    test_trap();
    test_instruction("after_trap", 6'h2B, 0, 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout passes=%0d checks=%0d", passes, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
